// File: rtl/cached_fetcher.sv
//------------------------------------------------------------------------------
// Module   : cached_fetcher
// Brief    : Instruction fetcher with a direct-mapped instruction cache.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module cached_fetcher #(
    parameter int PROGRAM_MEM_ADDR_BITS = 8,
    parameter int PROGRAM_MEM_DATA_BITS = 16,
    parameter int CACHE_LINES           = 4
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic [2:0]                       core_state,
    input  logic [PROGRAM_MEM_ADDR_BITS-1:0] current_pc,
    input  logic                             flush,
    output logic                             mem_read_valid,
    output logic [PROGRAM_MEM_ADDR_BITS-1:0] mem_read_address,
    input  logic                             mem_read_ready,
    input  logic [PROGRAM_MEM_DATA_BITS-1:0] mem_read_data,
    output logic [2:0]                       fetcher_state,
    output logic [PROGRAM_MEM_DATA_BITS-1:0] instruction,
    output logic [7:0]                       miss_count
);

    localparam int INDEX_BITS = $clog2(CACHE_LINES);
    localparam int TAG_BITS   = PROGRAM_MEM_ADDR_BITS - INDEX_BITS;

    localparam logic [2:0] c_CORE_FETCH  = 3'b001;
    localparam logic [2:0] c_CORE_DECODE = 3'b010;

    localparam logic [2:0] c_IDLE     = 3'b000;
    localparam logic [2:0] c_FETCHING = 3'b001;
    localparam logic [2:0] c_FETCHED  = 3'b010;

    logic [2:0]                       r_state;
    logic                             r_mem_valid;
    logic [PROGRAM_MEM_ADDR_BITS-1:0] r_mem_addr;
    logic [PROGRAM_MEM_DATA_BITS-1:0] r_instruction;
    logic [7:0]                       r_miss_count;
    logic [CACHE_LINES-1:0]           r_valid;
    logic [TAG_BITS-1:0]              r_tag  [CACHE_LINES];
    logic [PROGRAM_MEM_DATA_BITS-1:0] r_data [CACHE_LINES];

    logic [INDEX_BITS-1:0]            w_index;
    logic [TAG_BITS-1:0]              w_tag;
    logic                             w_hit;
    logic [INDEX_BITS-1:0]            w_fill_index;
    logic [TAG_BITS-1:0]              w_fill_tag;
    logic                             w_fill;

    assign w_index      = current_pc[INDEX_BITS-1:0];
    assign w_tag        = current_pc[PROGRAM_MEM_ADDR_BITS-1 -: TAG_BITS];
    assign w_hit        = r_valid[w_index] && (r_tag[w_index] == w_tag);
    // The held request address identifies the line to fill.
    assign w_fill_index = r_mem_addr[INDEX_BITS-1:0];
    assign w_fill_tag   = r_mem_addr[PROGRAM_MEM_ADDR_BITS-1 -: TAG_BITS];
    assign w_fill       = (r_state == c_FETCHING) && mem_read_ready;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state       <= c_IDLE;
            r_mem_valid   <= 1'b0;
            r_mem_addr    <= '0;
            r_instruction <= '0;
            r_miss_count  <= 8'd0;
            r_valid       <= '0;
        end else begin
            case (r_state)
                c_IDLE: begin
                    if (core_state == c_CORE_FETCH) begin
                        if (w_hit) begin
                            r_instruction <= r_data[w_index];
                            r_state       <= c_FETCHED;
                        end else begin
                            r_mem_valid <= 1'b1;
                            r_mem_addr  <= current_pc;
                            r_state     <= c_FETCHING;
                        end
                    end
                end
                c_FETCHING: begin
                    if (mem_read_ready) begin
                        r_mem_valid            <= 1'b0;
                        r_instruction          <= mem_read_data;
                        r_valid[w_fill_index]  <= 1'b1;
                        if (r_miss_count != 8'hFF) begin
                            r_miss_count <= r_miss_count + 8'd1;
                        end
                        r_state <= c_FETCHED;
                    end
                end
                c_FETCHED: begin
                    if (core_state == c_CORE_DECODE) begin
                        r_state <= c_IDLE;
                    end
                end
                default: begin
                    r_state     <= c_IDLE;
                    r_mem_valid <= 1'b0;
                end
            endcase
            // Flush overrides a coincident fill; the lookup above already used old bits.
            if (flush) begin
                r_valid <= '0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_fill) begin
            r_tag[w_fill_index]  <= w_fill_tag;
            r_data[w_fill_index] <= mem_read_data;
        end
    end

    assign fetcher_state    = r_state;
    assign mem_read_valid   = r_mem_valid;
    assign mem_read_address = r_mem_addr;
    assign instruction      = r_instruction;
    assign miss_count       = r_miss_count;

endmodule

`default_nettype wire

// File: doc/cached_fetcher.md
CACHED_FETCHER -- requirements
Module: cached_fetcher

Interface
REQ-001 SHALL have parameter PROGRAM_MEM_ADDR_BITS, default 8, program memory address width.
REQ-002 SHALL have parameter PROGRAM_MEM_DATA_BITS, default 16, instruction width.
REQ-003 SHALL have parameter CACHE_LINES, default 4, number of direct-mapped lines (power of two, ≥2).
REQ-004 SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-005 SHALL have port reset  input  1  asynchronous, active-low reset (asserted when 0).
REQ-006 SHALL have port core_state  input  3  core state from scheduler (FETCH=3'b001, DECODE=3'b010).
REQ-007 SHALL have port current_pc  input  ADDR_BITS  PC of instruction to fetch.
REQ-008 SHALL have port flush  input  1  invalidate all cache lines.
REQ-009 SHALL have port mem_read_valid  output  1  program memory read request.
REQ-010 SHALL have port mem_read_address  output  ADDR_BITS  request address.
REQ-011 SHALL have port mem_read_ready  input  1  memory response valid.
REQ-012 SHALL have port mem_read_data  input  DATA_BITS  response instruction.
REQ-013 SHALL have port fetcher_state  output  3  IDLE=3'b000, FETCHING=3'b001, FETCHED=3'b010.
REQ-014 SHALL have port instruction  output  DATA_BITS  fetched instruction, stable while FETCHED.
REQ-015 SHALL have port miss_count  output  8  saturating count of cache misses.

Function
REQ-016 SHALL split current_pc into index = pc[log2(CACHE_LINES)-1:0] and tag = remaining upper bits; each line holds valid, tag, data.
REQ-017 SHALL, in IDLE with core_state==FETCH and a valid tag match, load instruction from the line and enter FETCHED next cycle (1-cycle hit latency, no memory request).
REQ-018 SHALL, in IDLE with core_state==FETCH on a miss, set mem_read_valid=1, mem_read_address=current_pc, and enter FETCHING next cycle.
REQ-019 SHALL hold mem_read_valid and mem_read_address constant in FETCHING until the cycle mem_read_ready==1 is sampled.
REQ-020 SHALL, on mem_read_ready in FETCHING, clear mem_read_valid, latch mem_read_data to instruction, write data/tag/valid to the indexed line, increment miss_count, and enter FETCHED, all in that same edge.
REQ-021 SHALL ignore mem_read_ready outside FETCHING.
REQ-022 SHALL saturate miss_count at 255 (no wrap).
REQ-023 SHALL remain in FETCHED until core_state==DECODE, then return to IDLE next cycle; instruction keeps its value in IDLE.
REQ-024 SHALL not start a new fetch in IDLE unless core_state==FETCH; no fetch SHALL start in the same cycle FETCHED→IDLE occurs.
REQ-025 SHALL, on flush, clear all valid bits next edge in any state; an outstanding FETCHING request SHALL still complete and deliver instruction.
REQ-026 SHALL, when flush coincides with a fill (REQ-020), leave the filled line invalid (flush wins) while still delivering instruction.
REQ-027 SHALL, when flush coincides with an IDLE lookup, use pre-flush valid bits for that lookup.
REQ-028 SHALL never encode fetcher_state values other than 000/001/010; an unreachable encoding SHALL recover to IDLE.

Reset
REQ-029 SHALL, while reset==0, asynchronously force fetcher_state=IDLE, mem_read_valid=0, mem_read_address=0, instruction=0, miss_count=0, all valid bits=0.
REQ-030 SHALL, on reset mid-FETCHING, abandon the request (no line written, no count) and ignore any later mem_read_ready until a new miss.

Verification
REQ-031 SHALL cover cold miss: reset, core_state=FETCH, pc=0x05, ready after 3 cycles with data 0xA1B2 -> valid held 3 cycles, address 0x05, FETCHED with instruction=0xA1B2, miss_count=1.
REQ-032 SHALL cover hit: refetch pc=0x05 -> FETCHED one cycle after FETCH, mem_read_valid stays 0, miss_count=1.
REQ-033 SHALL cover conflict: fetch pc=0x09 (same index 1, tag differs) -> miss, line replaced; then pc=0x05 -> miss again, miss_count=3.
REQ-034 SHALL cover flush: after hit-filled pc=0x05, pulse flush, fetch pc=0x05 -> miss; flush coincident with fill -> instruction delivered, next fetch of same pc misses.
REQ-035 SHALL cover reset mid-operation and saturation: reset during FETCHING -> state IDLE, valid=0 immediately; 300 misses -> miss_count=255.
